// File: rtl/spi_config_master.sv
// SPI master (CPOL=0, CPHA=1, MSB first) that frames a byte stream into CS-low
// transactions and returns the MISO bytes captured in the same frame.
module spi_config_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs
);

    // One counter serves both the SCLK half-periods and the inter-frame CS gap.
    localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, NEXT, GAP} state_t;

    state_t         r_state, w_state_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic [2:0]     r_bit, w_bit_next;
    logic [7:0]     r_tx_shift, w_tx_shift_next;
    logic [7:0]     r_rx_shift, w_rx_shift_next;
    logic           r_last, w_last_next;
    logic           r_tx_ready, w_tx_ready_next;
    logic           r_rx_valid, w_rx_valid_next;
    logic [7:0]     r_rx_data, w_rx_data_next;
    logic           r_sclk, w_sclk_next;
    logic           r_mosi, w_mosi_next;
    logic           r_cs, w_cs_next;

    logic w_accept, w_div_done, w_gap_done;

    assign w_accept   = tx_valid && r_tx_ready;
    assign w_div_done = (r_cnt == CW'(CLK_DIV - 1));
    assign w_gap_done = (r_cnt == CW'(CS_GAP - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_last     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_rx_shift <= w_rx_shift_next;
            r_last     <= w_last_next;
            r_tx_ready <= w_tx_ready_next;
            r_rx_valid <= w_rx_valid_next;
            r_rx_data  <= w_rx_data_next;
            r_sclk     <= w_sclk_next;
            r_mosi     <= w_mosi_next;
            r_cs       <= w_cs_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt + CW'(1);
        w_bit_next      = r_bit;
        w_tx_shift_next = r_tx_shift;
        w_rx_shift_next = r_rx_shift;
        w_last_next     = r_last;
        w_rx_valid_next = 1'b0;
        w_rx_data_next  = r_rx_data;
        w_sclk_next     = r_sclk;
        w_mosi_next     = r_mosi;
        w_cs_next       = r_cs;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_accept) begin
                    w_tx_shift_next = tx_data;
                    w_last_next     = tx_last;
                    w_bit_next      = 3'd7;
                    w_cs_next       = 1'b0;
                    w_state_next    = SETUP;
                end
            end
            SETUP: begin
                if (w_div_done) begin
                    w_cnt_next   = '0;
                    w_sclk_next  = 1'b1;
                    w_mosi_next  = r_tx_shift[7];
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                // Trailing edge: sample MISO as SCLK falls.
                if (w_div_done) begin
                    w_cnt_next      = '0;
                    w_sclk_next     = 1'b0;
                    w_rx_shift_next = {r_rx_shift[6:0], spi_miso};
                    w_tx_shift_next = {r_tx_shift[6:0], 1'b0};
                    w_state_next    = LOW;
                end
            end
            LOW: begin
                if (w_div_done) begin
                    w_cnt_next = '0;
                    if (r_bit != 3'd0) begin
                        w_bit_next   = r_bit - 3'd1;
                        w_sclk_next  = 1'b1;
                        w_mosi_next  = r_tx_shift[7];
                        w_state_next = HIGH;
                    end else begin
                        w_rx_data_next  = r_rx_shift;
                        w_rx_valid_next = 1'b1;
                        if (r_last) begin
                            w_cs_next    = 1'b1;
                            w_mosi_next  = 1'b0;
                            w_state_next = GAP;
                        end else begin
                            w_state_next = NEXT;
                        end
                    end
                end
            end
            NEXT: begin
                w_cnt_next = '0;
                if (w_accept) begin
                    w_tx_shift_next = tx_data;
                    w_last_next     = tx_last;
                    w_bit_next      = 3'd7;
                    w_sclk_next     = 1'b1;
                    w_mosi_next     = tx_data[7];
                    w_state_next    = HIGH;
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Ready is registered so it is low while reset is held and rises one cycle after release.
        w_tx_ready_next = (w_state_next == IDLE) || (w_state_next == NEXT);
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = (r_state != IDLE);
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs   = r_cs;

endmodule
